seven_seg_reader: RTL and testbench

- Receive-side counterpart of the display driver: monitors a multiplexed 4-digit, 8-bit active-low segment bus plus active-low anode strobes and reconstructs the hex value shown on each digit.
- Sits on the board-test/loopback path: a driver's segment/anode outputs feed this block, and its digit registers are compared against the driver's input value.
- Inputs are synchronized, filtered for stability, decoded, and stored per digit.

---
 rtl/seven_seg_reader.sv | 167 ++++++++++++++++
 tb/tb_seven_seg_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_reader.sv
// Receive-side seven-segment bus reader: synchronizes a multiplexed active-low
// segment/anode bus, waits for each scan slot to settle, and decodes it per digit.
module seven_seg_reader #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  an_in,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_valid,
    output logic        pattern_err,
    output logic        new_sample,
    output logic [1:0]  sample_idx
);

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

    logic [11:0]      sync1;
    logic [11:0]      tup;
    logic [11:0]      tup_prev;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    state_t           state_nxt;
    logic             changed;
    logic             one_hot;
    logic [1:0]       idx;
    logic             capture;
    logic [3:0]       dec_val;
    logic             dec_hit;
    logic             blank;

    // Idle bus level is all ones, so the synchronizer resets to "everything off".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '1;
            tup      <= '1;
            tup_prev <= '1;
        end else begin
            sync1    <= {an_in, seg_in};
            tup      <= sync1;
            tup_prev <= tup;
        end
    end

    assign changed = (tup != tup_prev);
    assign blank   = (tup[7:1] == 7'b1111111);

    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (tup[11:8])
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // A change of the tuple always restarts the settle window; capture happens once per slot.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            WAIT: begin
                if (one_hot) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_nxt = one_hot ? SETTLE : WAIT;
                end else if (cnt == CNT_CAP) begin
                    capture   = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (changed) begin
                    state_nxt = one_hot ? SETTLE : WAIT;
                end
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'h0;
        case (tup[7:1])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            default:    dec_hit = 1'b0;
        endcase
    end

    // Blank and unknown patterns both invalidate the digit but keep its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            pattern_err <= 1'b0;
            new_sample  <= 1'b0;
            sample_idx  <= '0;
        end else begin
            new_sample <= capture;
            if (capture) begin
                sample_idx       <= idx;
                dp_out[idx]      <= ~tup[0];
                digit_valid[idx] <= dec_hit;
                if (dec_hit) begin
                    digits[{idx, 2'b00} +: 4] <= dec_val;
                end
            end
            if (capture && !dec_hit && !blank) begin
                pattern_err <= 1'b1;
            end else if (err_clr) begin
                pattern_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: directed scenarios plus random scans, all checked
// against a run-length based reference model of the display bus.
module tb_seven_seg_reader;

    localparam int STABLE = 16;
    localparam logic [6:0] HEX_PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  an_in = 4'hF;
    logic        err_clr = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        pattern_err;
    logic        new_sample;
    logic [1:0]  sample_idx;

    int compared = 0;
    int mismatched = 0;

    seven_seg_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .err_clr     (err_clr),
        .digits      (digits),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .new_sample  (new_sample),
        .sample_idx  (sample_idx)
    );

    always #5 clk = ~clk;

    // Reference model: a sample is taken when a tuple has been seen for exactly
    // STABLE consecutive edges, and the result appears two edges later.
    logic [11:0] h0, h1;
    int          rl0, rl1;
    logic [15:0] exp_digits;
    logic [3:0]  exp_dp, exp_valid;
    logic        exp_err, exp_new_sample;
    logic [1:0]  exp_sample_idx;
    int          model_pulses = 0;
    logic        m_cap, m_bad;
    int          m_idx, m_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 = '1; h1 = '1; rl0 = 0; rl1 = 0;
            exp_digits = '0; exp_dp = '0; exp_valid = '0;
            exp_err = 1'b0; exp_new_sample = 1'b0; exp_sample_idx = '0;
        end else begin
            m_cap = (rl1 == STABLE) && ($countones(~h1[11:8]) == 1);
            m_bad = 1'b0;
            if (m_cap) begin
                m_idx = 0;
                for (int i = 0; i < 4; i++) if (!h1[8+i]) m_idx = i;
                m_val = -1;
                for (int v = 0; v < 16; v++) if (h1[7:1] == HEX_PAT[v]) m_val = v;
                exp_sample_idx = m_idx[1:0];
                exp_dp[m_idx] = ~h1[0];
                if (m_val >= 0) begin
                    exp_digits[m_idx*4 +: 4] = m_val[3:0];
                    exp_valid[m_idx] = 1'b1;
                end else begin
                    exp_valid[m_idx] = 1'b0;
                    if (h1[7:1] != 7'h7F) m_bad = 1'b1;
                end
                model_pulses++;
            end
            exp_new_sample = m_cap;
            if (m_bad) exp_err = 1'b1;
            else if (err_clr) exp_err = 1'b0;
            rl1 = rl0;
            h1  = h0;
            rl0 = ({an_in, seg_in} == h0) ? rl0 + 1 : 1;
            h0  = {an_in, seg_in};
        end
    end

    // Cycle-by-cycle record of DUT/model disagreement and DUT pulses.
    int diff_cycles = 0;
    int dut_pulses = 0;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if ({digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx} !==
                {exp_digits, exp_dp, exp_valid, exp_err, exp_new_sample, exp_sample_idx})
                diff_cycles++;
            if (new_sample === 1'b1) dut_pulses++;
        end
    end

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int p0, d0;
        #1;
        compared++;
        if ({digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx} !== 28'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = dut_pulses; d0 = diff_cycles;
        hold(4'hF, 8'hFF, 30);
        compared++;
        if (dut_pulses - p0 !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle_pulses: got %0d, expected 0", dut_pulses - p0);
        end
        compared++;
        if (diff_cycles - d0 !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle_model: got %0d differing cycles, expected 0", diff_cycles - d0);
        end
    endtask

    task automatic test_static();
        int first = -1, cnt = 0;
        an_in = 4'b1110;
        seg_in = 8'b00001101;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (new_sample === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        compared++;
        if (first !== 18) begin
            mismatched++;
            $display("[TB] FAIL static_latency: got %0d, expected 18", first);
        end
        compared++;
        if (cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL static_pulse_count: got %0d, expected 1", cnt);
        end
        compared++;
        if ({digits[3:0], digit_valid, dp_out, sample_idx} !== {4'h3, 4'b0001, 4'b0000, 2'd0}) begin
            mismatched++;
            $display("[TB] FAIL static_state: got %h, expected %h",
                     {digits[3:0], digit_valid, dp_out, sample_idx}, {4'h3, 4'b0001, 4'b0000, 2'd0});
        end
    endtask

    task automatic test_scan();
        logic [3:0] ans [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] segs [4] = '{8'b10011111, 8'b00100101, 8'b00000010, 8'b01110001};
        int p0, d0;
        for (int s = 0; s < 2; s++) begin
            p0 = dut_pulses; d0 = diff_cycles;
            for (int d = 0; d < 4; d++) hold(ans[d], segs[d], 40);
            compared++;
            if (dut_pulses - p0 !== 4) begin
                mismatched++;
                $display("[TB] FAIL scan_pulses: got %0d, expected 4", dut_pulses - p0);
            end
            compared++;
            if (diff_cycles - d0 !== 0) begin
                mismatched++;
                $display("[TB] FAIL scan_model: got %0d differing cycles, expected 0", diff_cycles - d0);
            end
        end
        compared++;
        if ({digits, digit_valid, dp_out} !== {16'hF021, 4'b1111, 4'b0100}) begin
            mismatched++;
            $display("[TB] FAIL scan_state: got %h, expected %h",
                     {digits, digit_valid, dp_out}, {16'hF021, 4'b1111, 4'b0100});
        end
    endtask

    task automatic test_glitch();
        int first = -1, cnt = 0, gl = 0;
        hold(4'b1101, 8'b00100101, 40);
        seg_in = 8'b00100101 ^ 8'h20;
        repeat (5) begin
            @(negedge clk);
            if (new_sample === 1'b1) gl++;
        end
        seg_in = 8'b00100101;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (new_sample === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        compared++;
        if (gl !== 0) begin
            mismatched++;
            $display("[TB] FAIL glitch_pulses: got %0d, expected 0", gl);
        end
        compared++;
        if (first !== 18 || cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL glitch_recapture: got at %0d count %0d, expected at 18 count 1", first, cnt);
        end
        compared++;
        if ({digits[7:4], digit_valid[1], sample_idx} !== {4'h2, 1'b1, 2'd1}) begin
            mismatched++;
            $display("[TB] FAIL glitch_state: got %h, expected %h",
                     {digits[7:4], digit_valid[1], sample_idx}, {4'h2, 1'b1, 2'd1});
        end
    endtask

    task automatic test_bad_pattern();
        hold(4'b1011, 8'b11110000, 40);
        compared++;
        if ({pattern_err, digit_valid[2], digits[11:8], dp_out[2]} !== {1'b1, 1'b0, 4'h0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL bad_capture: got %h, expected %h",
                     {pattern_err, digit_valid[2], digits[11:8], dp_out[2]}, {1'b1, 1'b0, 4'h0, 1'b1});
        end
        hold(4'b1011, 8'hFF, 40);
        compared++;
        if ({pattern_err, digit_valid[2], digits[11:8], dp_out[2]} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL blank_capture: got %h, expected %h",
                     {pattern_err, digit_valid[2], digits[11:8], dp_out[2]}, {1'b1, 1'b0, 4'h0, 1'b0});
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        compared++;
        if (pattern_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_clear: got %b, expected 0", pattern_err);
        end
        an_in = 4'b1011;
        seg_in = 8'b11110001;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) err_clr = 1'b1;
        end
        err_clr = 1'b0;
        compared++;
        if ({new_sample, pattern_err} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL err_set_wins: got %b, expected 11", {new_sample, pattern_err});
        end
        @(negedge clk);
        compared++;
        if (pattern_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_sticky: got %b, expected 1", pattern_err);
        end
    endtask

    task automatic test_anode_conflict();
        logic [27:0] snap;
        int p0;
        snap = {exp_digits, exp_dp, exp_valid, exp_err, 1'b0, exp_sample_idx};
        p0 = dut_pulses;
        hold(4'b1100, 8'b00000001, 50);
        compared++;
        if (dut_pulses - p0 !== 0) begin
            mismatched++;
            $display("[TB] FAIL conflict_pulses: got %0d, expected 0", dut_pulses - p0);
        end
        compared++;
        if ({digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx} !== snap) begin
            mismatched++;
            $display("[TB] FAIL conflict_state: got %h, expected %h",
                     {digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx}, snap);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1, cnt = 0;
        hold(4'b1110, {HEX_PAT[5], 1'b1}, 8);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx} !== 28'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_outputs: got %h, expected 0",
                     {digits, dp_out, digit_valid, pattern_err, new_sample, sample_idx});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (new_sample === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        compared++;
        if (first !== 18 || cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_recapture: got at %0d count %0d, expected at 18 count 1", first, cnt);
        end
        compared++;
        if ({digits[3:0], digit_valid} !== {4'h5, 4'b0001}) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_state: got %h, expected %h", {digits[3:0], digit_valid}, {4'h5, 4'b0001});
        end
    endtask

    task automatic test_random();
        int p0, m0, d0, r, len, g_at, g_len;
        logic [3:0] an;
        logic [7:0] seg;
        p0 = dut_pulses; m0 = model_pulses; d0 = diff_cycles;
        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 9);
            an = ~(4'b0001 << $urandom_range(0, 3));
            if (r == 0) an = 4'($urandom);
            seg = {HEX_PAT[$urandom_range(0, 15)], 1'($urandom)};
            if (r == 1) seg = 8'($urandom);
            if (r == 2) seg = 8'hFF;
            len = $urandom_range(5, 40);
            g_at = (r >= 7) ? $urandom_range(0, len - 1) : -1;
            g_len = $urandom_range(1, 10);
            an_in = an;
            seg_in = seg;
            for (int c = 0; c < len; c++) begin
                if (c == g_at) seg_in = seg ^ 8'($urandom_range(1, 255));
                if (c == g_at + g_len) seg_in = seg;
                err_clr = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            err_clr = 1'b0;
            compared++;
            if ({digits, dp_out, digit_valid, pattern_err, sample_idx} !==
                {exp_digits, exp_dp, exp_valid, exp_err, exp_sample_idx}) begin
                mismatched++;
                $display("[TB] FAIL random_slot_%0d: got %h, expected %h", s,
                         {digits, dp_out, digit_valid, pattern_err, sample_idx},
                         {exp_digits, exp_dp, exp_valid, exp_err, exp_sample_idx});
            end
        end
        compared++;
        if (dut_pulses - p0 !== model_pulses - m0) begin
            mismatched++;
            $display("[TB] FAIL random_pulses: got %0d, expected %0d", dut_pulses - p0, model_pulses - m0);
        end
        compared++;
        if (diff_cycles - d0 !== 0) begin
            mismatched++;
            $display("[TB] FAIL random_model: got %0d differing cycles, expected 0", diff_cycles - d0);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_scan();
        test_glitch();
        test_bad_pattern();
        test_anode_conflict();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
